// File: rtl/refrigeracion_pkg.sv
// Shared types and defaults for the cooling controller blocks.
package refrigeracion_pkg;

  // Fan-speed level as produced by the temperature/setpoint comparator.
  typedef logic [1:0] giro_t;

  // Fan drive sequencing states.
  typedef enum logic [1:0] {
    PARADO   = 2'd0,
    ARRANQUE = 2'd1,
    RAMPA    = 2'd2,
    ESTABLE  = 2'd3
  } estado_t;

  // Default target duties for levels 1..3 (level 0 is always duty 0).
  localparam int DUTY_L1_DEF = 85;
  localparam int DUTY_L2_DEF = 170;
  localparam int DUTY_L3_DEF = 255;

endpackage

// File: rtl/pwm_ventilador_base.sv
// PWM time base: prescaler, period counter, registered comparator and
// end-of-period strobe. The counter period is 2^PWM_BITS-1 counts so that a
// duty of all ones gives a constant-high output.
module pwm_base #(
  parameter int PWM_BITS = 8,
  parameter int PRESC    = 50
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_pwm,
  output logic                o_fin_periodo
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]       PRESC_MAX = PW'(PRESC - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = PWM_BITS'((1 << PWM_BITS) - 2);

  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_cnt;
  logic                r_pwm;
  logic                w_tick;

  assign w_tick        = (r_presc == PRESC_MAX);
  assign o_fin_periodo = w_tick && (r_cnt == CNT_MAX);
  assign o_pwm         = r_pwm;

  // Prescaler: one tick every PRESC clocks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + 1'b1;
  end

  // Period counter 0..2^PWM_BITS-2, advancing on each tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    r_cnt <= '0;
    else if (w_tick) r_cnt <= (r_cnt == CNT_MAX) ? '0 : r_cnt + 1'b1;
  end

  // Registered compare keeps the motor drive free of combinational glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_pwm <= 1'b0;
    else          r_pwm <= (r_cnt < i_duty);
  end

endmodule

// File: rtl/pwm_ventilador.sv
// Fan motor driver: synchronizes and debounces the requested level, then
// sequences duty through a start kick and a slew-limited ramp.
module pwm_ventilador
  import refrigeracion_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PRESC        = 50,
  parameter int HOLD_PERIODS = 64,
  parameter int KICK_PERIODS = 16,
  parameter int RAMP_STEP    = 4,
  parameter int DUTY_L1      = DUTY_L1_DEF,
  parameter int DUTY_L2      = DUTY_L2_DEF,
  parameter int DUTY_L3      = DUTY_L3_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_giro,
  output logic                o_pwm_out,
  output logic [PWM_BITS-1:0] o_duty,
  output logic [1:0]          o_nivel,
  output logic                o_en_rampa
);

  localparam int HW = $clog2(HOLD_PERIODS + 1);
  localparam int KW = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [HW-1:0]       HOLD_MAX    = HW'(HOLD_PERIODS);
  localparam logic [HW-1:0]       HOLD_ULTIMO = HW'(HOLD_PERIODS - 1);
  localparam logic [KW-1:0]       KICK_ULTIMO = KW'(KICK_PERIODS - 1);
  localparam logic [PWM_BITS:0]   STEP        = (PWM_BITS + 1)'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] DUTY_MAX    = '1;

  giro_t               r_giro_s1, r_giro_s2, r_candidato, r_nivel;
  logic [HW-1:0]       r_estab_cnt;
  estado_t             r_estado, w_estado_sig;
  logic [PWM_BITS-1:0] r_duty, w_duty_sig, w_objetivo, w_paso;
  logic [KW-1:0]       r_kick_cnt, w_kick_sig;
  logic                r_en_rampa, w_en_rampa_sig;
  logic                w_fin_periodo;
  logic [PWM_BITS:0]   w_obj_ext, w_duty_ext, w_diff;

  pwm_base #(
    .PWM_BITS (PWM_BITS),
    .PRESC    (PRESC)
  ) u_pwm_base (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_duty        (r_duty),
    .o_pwm         (o_pwm_out),
    .o_fin_periodo (w_fin_periodo)
  );

  // Two-flop synchronizer for the asynchronous level request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_giro_s1 <= '0;
      r_giro_s2 <= '0;
    end else begin
      r_giro_s1 <= i_giro;
      r_giro_s2 <= r_giro_s1;
    end
  end

  // Debounce: a candidate must survive HOLD_PERIODS period ends unchanged.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_candidato <= '0;
      r_estab_cnt <= '0;
      r_nivel     <= '0;
    end else if (r_giro_s2 != r_candidato) begin
      r_candidato <= r_giro_s2;
      r_estab_cnt <= '0;
    end else if (w_fin_periodo) begin
      if (r_estab_cnt != HOLD_MAX) r_estab_cnt <= r_estab_cnt + 1'b1;
      if (r_estab_cnt >= HOLD_ULTIMO) r_nivel <= r_candidato;
    end
  end

  // Target duty lookup and one slew-limited step toward it (never overshoots).
  always_comb begin
    case (r_nivel)
      2'd1:    w_objetivo = PWM_BITS'(DUTY_L1);
      2'd2:    w_objetivo = PWM_BITS'(DUTY_L2);
      2'd3:    w_objetivo = PWM_BITS'(DUTY_L3);
      default: w_objetivo = '0;
    endcase
    w_obj_ext  = {1'b0, w_objetivo};
    w_duty_ext = {1'b0, r_duty};
    if (w_obj_ext >= w_duty_ext) begin
      w_diff = w_obj_ext - w_duty_ext;
      w_paso = (w_diff > STEP) ? r_duty + STEP[PWM_BITS-1:0] : w_objetivo;
    end else begin
      w_diff = w_duty_ext - w_obj_ext;
      w_paso = (w_diff > STEP) ? r_duty - STEP[PWM_BITS-1:0] : w_objetivo;
    end
  end

  // state    | meaning
  // PARADO   | motor off, duty 0, waiting for a nonzero level
  // ARRANQUE | full-duty kick for KICK_PERIODS periods
  // RAMPA    | duty slewing toward the target by at most RAMP_STEP per period
  // ESTABLE  | duty equals target
  // Next-state logic; everything moves only at period ends, level 0 wins.
  always_comb begin
    w_estado_sig = r_estado;
    w_duty_sig   = r_duty;
    w_kick_sig   = r_kick_cnt;
    if (w_fin_periodo) begin
      if (r_nivel == 2'd0) begin
        w_estado_sig = PARADO;
        w_duty_sig   = '0;
        w_kick_sig   = '0;
      end else begin
        case (r_estado)
          PARADO: begin
            w_estado_sig = ARRANQUE;
            w_duty_sig   = DUTY_MAX;
            w_kick_sig   = '0;
          end
          ARRANQUE: begin
            if (r_kick_cnt == KICK_ULTIMO) begin
              w_duty_sig   = w_paso;
              w_estado_sig = (w_paso == w_objetivo) ? ESTABLE : RAMPA;
            end else begin
              w_kick_sig = r_kick_cnt + 1'b1;
            end
          end
          RAMPA: begin
            w_duty_sig   = w_paso;
            w_estado_sig = (w_paso == w_objetivo) ? ESTABLE : RAMPA;
          end
          ESTABLE: begin
            if (w_objetivo != r_duty) begin
              w_duty_sig   = w_paso;
              w_estado_sig = (w_paso == w_objetivo) ? ESTABLE : RAMPA;
            end
          end
          default: begin
            w_estado_sig = PARADO;
            w_duty_sig   = '0;
          end
        endcase
      end
    end
    w_en_rampa_sig = (w_estado_sig == ARRANQUE) || (w_estado_sig == RAMPA);
  end

  // State, duty, kick counter and ramp flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado   <= PARADO;
      r_duty     <= '0;
      r_kick_cnt <= '0;
      r_en_rampa <= 1'b0;
    end else begin
      r_estado   <= w_estado_sig;
      r_duty     <= w_duty_sig;
      r_kick_cnt <= w_kick_sig;
      r_en_rampa <= w_en_rampa_sig;
    end
  end

  assign o_duty     = r_duty;
  assign o_nivel    = r_nivel;
  assign o_en_rampa = r_en_rampa;

endmodule

// File: tb/tb_pwm_ventilador.sv
// Scoreboard bench for pwm_ventilador with a short PWM period (PRESC=1).
module tb_pwm_ventilador;

  localparam int PERIODO = 255;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] giro = 2'd0;
  logic       pwm_out;
  logic [7:0] duty;
  logic [1:0] nivel;
  logic       en_rampa;

  always #5 clk = ~clk;

  pwm_ventilador #(
    .PWM_BITS     (8),
    .PRESC        (1),
    .HOLD_PERIODS (2),
    .KICK_PERIODS (2),
    .RAMP_STEP    (40),
    .DUTY_L1      (85),
    .DUTY_L2      (170),
    .DUTY_L3      (255)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_giro     (giro),
    .o_pwm_out  (pwm_out),
    .o_duty     (duty),
    .o_nivel    (nivel),
    .o_en_rampa (en_rampa)
  );

  typedef struct packed {
    logic [7:0] duty;
    logic       en;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail = 0;
  logic       mon_en = 1'b0;
  logic [7:0] prev_duty = 8'd0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push(input int d, input int e);
    exp_t x;
    x.duty = 8'(d);
    x.en   = 1'(e);
    exp_q.push_back(x);
  endtask

  // Monitor: every duty change is a DUT output event checked against the queue.
  always @(negedge clk) begin
    if (mon_en && (duty !== prev_duty)) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL duty_inesperado: got duty %0d, required no change from %0d", duty, prev_duty);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (duty !== e.duty || en_rampa !== e.en) begin
          n_fail++;
          $display("FAIL paso_duty: got duty %0d en_rampa %0d, required duty %0d en_rampa %0d",
                   duty, en_rampa, e.duty, e.en);
        end
      end
      prev_duty = duty;
    end
  end

  task automatic wait_q_empty(input string name, input int max_ciclos);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_ciclos) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, got %0d pending steps, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_duty(input string name, input int val, input int max_ciclos);
    int k;
    k = 0;
    while (int'(duty) != val && k < max_ciclos) begin
      @(negedge clk);
      k++;
    end
    if (int'(duty) != val) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout, got duty %0d, required %0d", name, duty, val);
    end
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (PERIODO) begin
      @(negedge clk);
      if (pwm_out) n++;
    end
  endtask

  initial begin
    int h;
    int t;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("reset_pwm_out", pwm_out, 0);
    check("reset_duty", duty, 0);
    check("reset_nivel", nivel, 0);
    check("reset_en_rampa", en_rampa, 0);
    prev_duty = 8'd0;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * PERIODO) @(negedge clk);
    check("reposo_duty", duty, 0);

    // Start from rest and ramp down to level 1
    push(255, 1); push(215, 1); push(175, 1); push(135, 1); push(95, 1); push(85, 0);
    giro = 2'd1;
    wait_duty("kick_inicio", 255, 6 * PERIODO);
    t = 0;
    while (duty == 8'd255 && t < 4 * PERIODO) begin
      @(negedge clk);
      t++;
    end
    check("kick_ciclos", t, 2 * PERIODO);
    check("nivel_1", nivel, 1);
    wait_q_empty("rampa_bajada", 10 * PERIODO);
    repeat (2 * PERIODO) @(negedge clk);
    check("estable_85_duty", duty, 85);
    check("estable_85_en_rampa", en_rampa, 0);

    // Glitch shorter than a period is rejected
    giro = 2'd2;
    repeat (50) @(negedge clk);
    giro = 2'd1;
    repeat (4 * PERIODO) @(negedge clk);
    check("glitch_nivel", nivel, 1);
    check("glitch_duty", duty, 85);
    count_high(h);
    check("altos_85", h, 85);

    // Ramp up to level 3 without a kick
    push(125, 1); push(165, 1); push(205, 1); push(245, 1); push(255, 0);
    giro = 2'd3;
    wait_q_empty("rampa_subida", 12 * PERIODO);
    check("nivel_3", nivel, 3);
    count_high(h);
    check("altos_255", h, 255);

    // Down to level 2
    push(215, 1); push(175, 1); push(170, 0);
    giro = 2'd2;
    wait_q_empty("rampa_170", 10 * PERIODO);
    count_high(h);
    check("altos_170", h, 170);

    // Level 0 stops at once
    push(0, 0);
    giro = 2'd0;
    wait_q_empty("parada", 8 * PERIODO);
    check("parada_nivel", nivel, 0);
    count_high(h);
    check("altos_0", h, 0);

    // Stop requested during the kick: acceptance lands on the kick's last
    // boundary, so one ramp step is seen before the cut to 0.
    push(255, 1); push(215, 1); push(0, 0);
    giro = 2'd1;
    wait_duty("kick_parada_inicio", 255, 6 * PERIODO);
    giro = 2'd0;
    wait_q_empty("kick_parada", 8 * PERIODO);
    check("kick_parada_nivel", nivel, 0);
    check("kick_parada_en_rampa", en_rampa, 0);
    count_high(h);
    check("kick_parada_altos", h, 0);

    // Asynchronous reset during RAMPA while pwm_out is high
    push(255, 1); push(215, 1);
    giro = 2'd1;
    wait_q_empty("pre_reset", 10 * PERIODO);
    t = 0;
    while (!pwm_out && t < PERIODO) begin
      @(negedge clk);
      t++;
    end
    check("pre_reset_pwm_alto", pwm_out, 1);
    push(0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pwm_out", pwm_out, 0);
    check("rst_duty", duty, 0);
    check("rst_nivel", nivel, 0);
    check("rst_en_rampa", en_rampa, 0);
    giro = 2'd0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * PERIODO) @(negedge clk);
    check("post_rst_duty", duty, 0);
    check("post_rst_nivel", nivel, 0);
    check("post_rst_en_rampa", en_rampa, 0);

    // From PARADO after reset a new request kicks again
    push(255, 1); push(215, 1); push(175, 1); push(135, 1); push(95, 1); push(85, 0);
    giro = 2'd1;
    wait_q_empty("rearranque", 16 * PERIODO);
    check("rearranque_duty", duty, 85);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_ventilador.md
# pwm_ventilador

Downstream stage of the cooling controller. Consumes the 2-bit fan-speed level (`giro`) from the temperature/setpoint comparator and drives the fan motor with a glitch-free PWM signal. Input levels are debounced over whole PWM periods. Starting from rest applies a full-duty kick. Every other duty change is slew-limited so sensor noise cannot chatter the motor.

## Interface
- `PWM_BITS`, default 8: duty/counter width; PWM period = 2^PWM_BITS−1 counts.
- `PRESC`, default 50: clocks per PWM count (≥1).
- `HOLD_PERIODS`, default 64: PWM periods a new `giro` must be stable before acceptance (≥1).
- `KICK_PERIODS`, default 16: PWM periods of full duty on start from rest (≥1).
- `RAMP_STEP`, default 4: maximum duty change per PWM period (≥1).
- `DUTY_L1` / `DUTY_L2` / `DUTY_L3`, defaults 85 / 170 / 255: target duty for levels 1/2/3. Level 0 is duty 0.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `giro` in 2: requested speed level, asynchronous to `clk`.
- `pwm_out` out 1: motor drive.
- `duty` out PWM_BITS: duty currently applied.
- `nivel` out 2: accepted (debounced) level.
- `en_rampa` out 1: high in ARRANQUE or RAMPA.

## Operation
- Reset values: `pwm_out`=0, `duty`=0, `nivel`=0, `en_rampa`=0. State PARADO. All counters 0. Reset takes effect immediately, including mid-kick or mid-ramp.
- `giro` passes through a 2-flop synchronizer.
- **Prescaler:** `tick` is high when the prescaler = PRESC−1.
- **PWM counter:** `cnt` runs 0..2^PWM_BITS−2 and advances on `tick`. `fin_periodo` = `tick` && `cnt` at max.
- **PWM output:** `pwm_out` is registered from (`cnt` < `duty`). Duty 0 is constant low. Duty 255 is constant high.
- **Debounce:**
  - On any clock where the synchronized `giro` ≠ `candidato`: `candidato` ← synchronized value, stability count ← 0.
  - On `fin_periodo` with no mismatch: stability count increments, saturating.
  - When the count reaches HOLD_PERIODS, `nivel` ← `candidato`.
  - A new value equal to the current `nivel` changes nothing.
- **Target:** `objetivo` is taken from `nivel` using the DUTY_Lx parameters.
- **Update rule:** `duty` and the FSM update only on `fin_periodo`.
- **FSM:**
  - PARADO: `duty`=0. If `nivel`≠0, go to ARRANQUE and set `duty`=2^PWM_BITS−1.
  - ARRANQUE: full duty for KICK_PERIODS periods. Then go to RAMPA, or to ESTABLE if `objetivo` is full duty.
  - RAMPA: move `duty` toward `objetivo` by min(RAMP_STEP, |diff|), in either direction. When equal, go to ESTABLE.
  - ESTABLE: if `objetivo` ≠ `duty` and `nivel`≠0, go to RAMPA.
  - Any state: `nivel`=0 at `fin_periodo` gives `duty`←0 and PARADO with no ramp-down. This takes priority over every other transition.
- **Mid-ramp target change:** ramping continues toward the new `objetivo` without re-kicking.
- **Mid-kick target change:** the kick completes unless `nivel`=0.
- **Arithmetic:** difference computed at PWM_BITS+1 bits. The step result never overshoots and never wraps.

## Timing
- PWM period = (2^PWM_BITS−1)·PRESC clocks. With defaults: 12 750 clocks.
- `pwm_out` lags `cnt` by 1 clock. Duty changes only at period boundaries, so there are no runt pulses.
- `giro` step to `nivel` update: 2 sync clocks + HOLD_PERIODS period boundaries, counted from the first boundary after synchronization.
- `nivel` 0→nonzero: full duty from the next `fin_periodo`. The kick lasts exactly KICK_PERIODS periods.
- `en_rampa` is registered with the state. It rises and falls on the same clock as the state change.

## Structure
- Shared package `refrigeracion_pkg`:
  - `giro_t` (2-bit level encoding, shared with the comparator).
  - FSM state enum {PARADO, ARRANQUE, RAMPA, ESTABLE}.
  - Default DUTY_Lx constants.
- One natural sub-module, `pwm_base`: prescaler, period counter, comparator, and `fin_periodo` generation.
- Debounce and FSM stay in the top module.

## Test plan
Bench parameters: PRESC=1, HOLD_PERIODS=2, KICK_PERIODS=2, RAMP_STEP=40.
- Reset mid-operation:
  - Stimulus: assert `rst_n`=0 during RAMPA.
  - Required response: `pwm_out`, `duty`, `nivel`, `en_rampa` are 0 in the same cycle; state is PARADO after release.
- Start and ramp down:
  - Stimulus: `giro` 0→1 held.
  - Required response: `nivel`=1 after 2 boundaries; `duty`=255 for 2 periods; then 215, 175, 135, 95, 85; then ESTABLE with `en_rampa`=0.
- Ramp up:
  - Stimulus: in ESTABLE at 85, `giro`→3.
  - Required response: `duty` 125, 165, 205, 245, 255, with no kick.
- Glitch rejection:
  - Stimulus: `giro` pulses 1→2→1 for less than one period.
  - Required response: `nivel` stays 1; `duty` unchanged.
- Immediate stop:
  - Stimulus: `giro`→0 during ARRANQUE.
  - Required response: `duty`=0 and PARADO at the boundary after acceptance; `pwm_out` constant low.
- Duty waveform:
  - Stimulus: duty 0 and duty 255.
  - Required response: exactly 0 and 255 high counts per 255-count period.
  - Stimulus: duty 170.
  - Required response: exactly 170 high counts per period.
